// File: rtl/dmem_arbiter_pkg.sv
// mem_arb_pkg: shared constants for the data-memory arbiter.
// Port indices and the read encoding of the byte write mask.
package mem_arb_pkg;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef logic [3:0] be_t;

  localparam be_t WE_READ = 4'b0000;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester ports (cpu, debug) plus dmem port.
// slave = arbiter side, master = requesters and memory side.
interface dmem_arbiter_if #(
  parameter int AWIDTH = 14,
  parameter int DWIDTH = 32
);

  logic              req0_valid;
  logic              req0_ready;
  logic [AWIDTH-1:0] req0_addr;
  logic [DWIDTH-1:0] req0_wdata;
  logic [3:0]        req0_we;
  logic              req0_rvalid;
  logic [DWIDTH-1:0] req0_rdata;

  logic              req1_valid;
  logic              req1_ready;
  logic [AWIDTH-1:0] req1_addr;
  logic [DWIDTH-1:0] req1_wdata;
  logic [3:0]        req1_we;
  logic              req1_rvalid;
  logic [DWIDTH-1:0] req1_rdata;
  logic              req1_lock;

  logic              mem_en;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_din;
  logic [3:0]        mem_we;
  logic [DWIDTH-1:0] mem_dout;

  modport slave (
    input  req0_valid, req0_addr,
    input  req0_wdata, req0_we,
    output req0_ready, req0_rvalid,
    output req0_rdata,
    input  req1_valid, req1_addr,
    input  req1_wdata, req1_we,
    input  req1_lock,
    output req1_ready, req1_rvalid,
    output req1_rdata,
    output mem_en, mem_addr,
    output mem_din, mem_we,
    input  mem_dout
  );

  modport master (
    output req0_valid, req0_addr,
    output req0_wdata, req0_we,
    input  req0_ready, req0_rvalid,
    input  req0_rdata,
    output req1_valid, req1_addr,
    output req1_wdata, req1_we,
    output req1_lock,
    input  req1_ready, req1_rvalid,
    input  req1_rdata,
    input  mem_en, mem_addr,
    input  mem_din, mem_we,
    output mem_dout
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: 2-way round-robin grant with bounded port-1 lock.
// In: valid0/1, lock1, rst_ni. Out: one-hot gnt0/gnt1.
module rr_arb2
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic lock1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  localparam logic [7:0] CNT_LIM =
    8'(MAX_LOCK - 1);

  logic       last_q, last_d;
  logic       lock_q, lock_d;
  logic [7:0] cnt_q, cnt_d;

  // Reset forces both grants low.
  always_comb begin
    gnt1_o = rst_ni && valid1_i &&
             (lock_q || !valid0_i ||
              last_q == PORT_CPU);
    gnt0_o = rst_ni && valid0_i && !gnt1_o;
  end

  always_comb begin
    last_d = last_q;
    lock_d = lock_q;
    cnt_d  = cnt_q;
    if (gnt1_o) begin
      last_d = PORT_DBG;
      if (lock1_i && cnt_q < CNT_LIM) begin
        lock_d = 1'b1;
        cnt_d  = cnt_q + 8'd1;
      end else begin
        lock_d = 1'b0;
        cnt_d  = '0;
      end
    end else begin
      if (gnt0_o) last_d = PORT_CPU;
      // Locked but port 1 dropped valid:
      // release and hand next contention
      // to the cpu port.
      if (lock_q) begin
        lock_d = 1'b0;
        cnt_d  = '0;
        last_d = PORT_DBG;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= PORT_DBG;
      lock_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      last_q <= last_d;
      lock_q <= lock_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one sync-read dmem between cpu and debug.
// Ports: clk, rst (async, active-low), bus (slave modport).
module dmem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AWIDTH   = 14,
  parameter int DWIDTH   = 32,
  parameter int unsigned MAX_LOCK = 16
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  logic              gnt0, gnt1, xfer;
  logic [AWIDTH-1:0] addr_mux;
  logic [DWIDTH-1:0] din_mux;
  be_t               we_mux;
  logic rd_pend_q, rd_pend_d;
  logic rd_tag_q, rd_tag_d;

  rr_arb2 #(
    .MAX_LOCK(MAX_LOCK)
  ) u_arb (
    .clk_i   (clk),
    .rst_ni  (rst),
    .valid0_i(bus.req0_valid),
    .valid1_i(bus.req1_valid),
    .lock1_i (bus.req1_lock),
    .gnt0_o  (gnt0),
    .gnt1_o  (gnt1)
  );

  assign xfer = gnt0 | gnt1;

  // Idle: port-0 address/data, no write.
  always_comb begin
    addr_mux = bus.req0_addr;
    din_mux  = bus.req0_wdata;
    we_mux   = WE_READ;
    if (gnt1) begin
      addr_mux = bus.req1_addr;
      din_mux  = bus.req1_wdata;
      we_mux   = bus.req1_we;
    end else if (gnt0) begin
      we_mux   = bus.req0_we;
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.mem_en     = xfer;
  assign bus.mem_addr   = addr_mux;
  assign bus.mem_din    = din_mux;
  assign bus.mem_we     = we_mux;

  always_comb begin
    rd_pend_d = xfer && we_mux == WE_READ;
    rd_tag_d  = gnt1 ? PORT_DBG : PORT_CPU;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend_q <= 1'b0;
      rd_tag_q  <= PORT_CPU;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_tag_q  <= rd_tag_d;
    end
  end

  assign bus.req0_rvalid =
    rd_pend_q && rd_tag_q == PORT_CPU;
  assign bus.req1_rvalid =
    rd_pend_q && rd_tag_q == PORT_DBG;
  assign bus.req0_rdata  = bus.mem_dout;
  assign bus.req1_rdata  = bus.mem_dout;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port, synchronous-read data memory (one-cycle read latency) between two requesters.
- Port 0 is the CPU load/store port. Port 1 is the debug/DMA loader, which writes program images over UART.
- Arbitration is round-robin with an optional bounded lock for port-1 bursts.
- Sits between the cpu datapath memory stage and the dmem instance.

Parameters:
- AWIDTH, 14, word-address width of the data memory.
- DWIDTH, 32, data width (must be 32; byte write mask is DWIDTH/8).
- MAX_LOCK, 16, maximum consecutive port-1 grants under lock before a forced release (range 1..255).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- req0_valid  in  1  port 0 request.
- req0_ready  out  1  port 0 granted this cycle.
- req0_addr  in  AWIDTH  port 0 word address.
- req0_wdata  in  DWIDTH  port 0 write data.
- req0_we  in  4  port 0 byte write mask; 0 = read.
- req0_rvalid  out  1  port 0 read data valid.
- req0_rdata  out  DWIDTH  port 0 read data.
- req1_valid / req1_ready / req1_addr / req1_wdata / req1_we / req1_rvalid / req1_rdata  same as port 0, for port 1.
- req1_lock  in  1  port 1 requests to keep the grant next cycle.
- mem_en  out  1  memory enable.
- mem_addr  out  AWIDTH  memory address.
- mem_din  out  DWIDTH  memory write data.
- mem_we  out  4  memory byte write enable.
- mem_dout  in  DWIDTH  memory read data, valid the cycle after mem_en with mem_we == 0.

Behaviour:
- Grant is combinational from valid, last_grant and lock state. A transfer occurs when reqN_valid && reqN_ready.
- Requesters must hold addr, wdata and we stable while valid is high and ready is low.
- Only the winner sees ready = 1. mem_en = 1 iff a transfer occurs. mem_addr, mem_din and mem_we are muxed from the winner.
- With no transfer: mem_en = 0, mem_we = 0, and mem_addr/mem_din hold the port-0 values (don't care).
- Arbitration with no lock:
  - Only one port valid: that port wins.
  - Both valid: the port not granted last wins.
  - last_grant updates only on a transfer.
- Lock:
  - If port 1 transferred with req1_lock = 1 and lock_cnt < MAX_LOCK-1, the lock is held and port 1 wins next cycle whenever req1_valid = 1, regardless of port 0.
  - lock_cnt increments per locked port-1 transfer.
  - Lock is released when req1_lock = 0, or req1_valid = 0, or lock_cnt reaches MAX_LOCK-1. On release, lock_cnt is cleared, last_grant = 1, and port 0 wins the next contended cycle.
  - MAX_LOCK = 1 disables locking.
- Read return:
  - A read transfer (we == 0) registers rd_pend = 1 and rd_tag = winning port.
  - The next cycle asserts reqX_rvalid = 1 for exactly one cycle on the tagged port, with reqX_rdata = mem_dout.
  - The other port sees rvalid = 0. rdata is driven from mem_dout on both ports; it is meaningful only when rvalid = 1.
  - Write transfers produce no rvalid.
- Back-to-back transfers are allowed every cycle. Throughput is one access per cycle; read latency is 1 cycle from the transfer.
- Reset (rst = 0, asynchronous):
  - last_grant = 1, so port 0 wins the first contention.
  - Lock inactive, lock_cnt = 0, rd_pend = 0.
  - All rvalid = 0.
  - While in reset: ready = 0 and mem_en = 0 combinationally.
  - A read in flight when reset asserts is dropped; no rvalid after reset release.
- State is last_grant (1b), lock_act (1b), lock_cnt (8b), rd_pend (1b) and rd_tag (1b); no other storage.

Decomposition:
- Shared package (mem_arb_pkg): port index constants PORT_CPU = 0 and PORT_DBG = 1, and the WE_READ = 4'b0000 encoding.
- One natural sub-module, rr_arb2: the 2-way round-robin grant with lock input and last_grant state.
- The data/address mux and read-return tracking stay in the top module.

Test Plan:
- Reset release, then port 0 only: write 0xDEADBEEF to address 0x010 with we = 4'hF, then read 0x010 → one-cycle ready on the write; req0_rvalid = 1 the cycle after the read transfer, rdata = 0xDEADBEEF; req1_rvalid stays 0.
- Both valid continuously with reads, no lock, from reset → grants alternate 0,1,0,1; each port's rvalid follows its own grant by exactly 1 cycle.
- Port 1 holds req1_lock = 1 and valid, port 0 valid, MAX_LOCK = 4 → port 1 gets exactly 4 consecutive grants, then port 0 wins the next cycle.
- Byte write: write 0x11223344 to address 0x020, then write 0x000000AA with we = 4'b0001, then read 0x020 → rdata = 0x112233AA.
- rst driven low the cycle after a port-1 read transfer → req1_rvalid never asserts; after release, mem_en = 0 until a new valid, and first contention goes to port 0.
- Port 0 valid with the address held stable while port 1 is locked for 3 cycles → port 0 transfer completes only after the lock releases; mem_addr equals the port-0 address on that cycle.
